// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg: cache-bus request/response types, length encodings and arbiter state.
package cbus_arbiter_pkg;
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  // Length codes are beats-1, so the beat count is a plain increment.
  function automatic logic [4:0] len_to_beats(cbus_len_t len);
    return {1'b0, len} + 5'd1;
  endfunction
endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// cbus_arbiter_rr_pick: first valid requester at or above ptr, wrapping upward.
module cbus_arbiter_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW:0] s;
  always_comb begin
    any = |valid;
    idx = '0;
    s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (IW+1)'(i);
      s = (s >= (IW+1)'(NUM_REQ)) ? s - (IW+1)'(NUM_REQ) : s;
      idx = valid[s[IW-1:0]] ? s[IW-1:0] : idx;
    end
  end
endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants one upstream master a whole burst at a time and routes its responses.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  cbus_req_t  [NUM_REQ-1:0]     ireqs,
  output cbus_resp_t [NUM_REQ-1:0]     oresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   iresp,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         proto_err
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state_q, state_d;
  logic [IW-1:0] sel_q, sel_d, rr_q, rr_d, win;
  logic [4:0] beats_q, beats_d;
  logic err_q, err_d, any;
  logic [NUM_REQ-1:0] valids;
  logic [5:0] beats_inc, beats_exp;
  always_comb begin
    valids = '0;
    for (int i = 0; i < NUM_REQ; i++) valids[i] = ireqs[i].valid;
  end
  cbus_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (valids),
    .ptr   (ROUND_ROBIN ? rr_q : '0),
    .any   (any),
    .idx   (win)
  );
  assign beats_inc = {1'b0, beats_q} + 6'd1;
  assign beats_exp = {1'b0, len_to_beats(ireqs[sel_q].len)};
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    beats_d = beats_q;
    err_d   = err_q;
    oreq    = '0;
    oresps  = '0;
    if (state_q == IDLE) begin
      if (any) begin
        state_d = BUSY;
        sel_d   = win;
        beats_d = '0;
        rr_d    = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
    end else begin
      oreq          = ireqs[sel_q];
      oresps[sel_q] = iresp;
      if (iresp.ready) begin
        beats_d = (beats_q == 5'd31) ? beats_q : beats_q + 5'd1;
        // A short burst and an overrun both latch the error; termination still waits for last.
        err_d   = err_q | (iresp.last ? beats_inc != beats_exp : beats_inc == beats_exp);
        state_d = iresp.last ? IDLE : BUSY;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end
  assign busy      = (state_q == BUSY);
  assign grant_id  = sel_q;
  assign proto_err = err_q;
endmodule
